// File: rtl/spi_dcd_pkg.sv
// Shared definitions for the SPI instruction decoder: state encoding,
// header bit positions and register word width derivation.
package spi_dcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR_RD = 2'd1,
        DATA   = 2'd2,
        HOLD   = 2'd3
    } dcd_state_e;

    localparam int unsigned HDR_RW_BIT     = 7;
    localparam int unsigned HDR_BURST_BIT  = 6;
    localparam int unsigned HDR_ADDR_MAX_W = 6;

    function automatic int unsigned data_w(input int unsigned bytes);
        return 8 * bytes;
    endfunction

endpackage

// File: rtl/spi_dcd_word_buf.sv
// Register word buffer: holds the read shadow or the write assembly word,
// shifts one byte per transfer MSB first and tracks the byte index.
module spi_dcd_word_buf
    import spi_dcd_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 1,
    localparam int unsigned DATA_W = data_w(DATA_BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_val_i,
    input  logic              shift_i,
    input  logic [7:0]        byte_i,
    output logic [7:0]        ms_byte_o,
    output logic [DATA_W-1:0] shifted_c_o,
    output logic              last_c_o
);

    localparam int unsigned      IDX_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BYTES - 1);

    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] base_c;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Word consumed this cycle: a freshly fetched register word when loading
    assign base_c = load_i ? load_val_i : word_q;

    // Word after shifting the current byte in at the bottom
    generate
        if (DATA_BYTES == 1) begin : g_one
            assign shifted_c_o = byte_i;
        end else begin : g_multi
            assign shifted_c_o = {base_c[DATA_W-9:0], byte_i};
        end
    endgenerate

    assign last_c_o  = (idx_q == IDX_LAST);
    assign ms_byte_o = word_q[DATA_W-1 -: 8];

    // Next word and byte index
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear_i) begin
            word_d = '0;
            idx_d  = '0;
        end else if (shift_i) begin
            word_d = shifted_c_o;
            idx_d  = last_c_o ? '0 : idx_q + 1'b1;
        end else if (load_i) begin
            word_d = base_c;
            idx_d  = '0;
        end
    end

    // Buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/spi_burst_instr_dcd.sv
// SPI instruction decoder: header byte (rw, burst, addr) followed by
// DATA_BYTES-wide register words, with optional burst auto-increment.
// Optional mid-frame idle timeout enabled by defining SPI_DCD_TIMEOUT_EN.
module spi_burst_instr_dcd
    import spi_dcd_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_BYTES  = 1,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned DATA_W = data_w(DATA_BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    input  logic              frame_end,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_read,
    output logic [DATA_W-1:0] data_write,
    output logic              busy,
    output logic              err
);

    // Reject unsupported configurations at elaboration
    if (ADDR_W < 1 || ADDR_W > HDR_ADDR_MAX_W || DATA_BYTES < 1 || DATA_BYTES > 4
        || TIMEOUT_CYC < 2) begin : g_param_chk
        $error("spi_burst_instr_dcd: parameter out of range");
    end

    dcd_state_e        state_q, state_d;
    logic              rw_q, rw_d;
    logic              burst_q, burst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] dw_q, dw_d;
    logic              busy_q, busy_d;

    logic              wb_clear, wb_load, wb_shift;
    logic [7:0]        wb_ms_byte;
    logic [DATA_W-1:0] wb_shifted;
    logic              wb_last;
    logic              hdr_acc_c;
    logic              timeout_c;

    assign hdr_acc_c = (state_q == IDLE) && byte_sync && !frame_end;

    spi_dcd_word_buf #(
        .DATA_BYTES (DATA_BYTES)
    ) u_word_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (wb_clear),
        .load_i      (wb_load),
        .load_val_i  (data_read),
        .shift_i     (wb_shift),
        .byte_i      (data_in),
        .ms_byte_o   (wb_ms_byte),
        .shifted_c_o (wb_shifted),
        .last_c_o    (wb_last)
    );

`ifdef SPI_DCD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q, err_d;

    assign timeout_c = busy_q && !byte_sync && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    // Idle-cycle counter, restarted by every received byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (!busy_q || byte_sync || timeout_c) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Sticky timeout flag, cleared when the next header is accepted
    always_comb begin
        err_d = err_q;
        if (timeout_c) begin
            err_d = 1'b1;
        end else if (hdr_acc_c) begin
            err_d = 1'b0;
        end
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_c = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state and strobe decode
    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        burst_d  = burst_q;
        addr_d   = addr_q;
        read_d   = 1'b0;
        write_d  = 1'b0;
        dw_d     = dw_q;
        wb_clear = 1'b0;
        wb_load  = 1'b0;
        wb_shift = 1'b0;

        // Burst write steps the address once the strobe cycle is over
        if (write_q && burst_q) begin
            addr_d = addr_q + 1'b1;
        end

        if (state_q != IDLE && (frame_end || timeout_c)) begin
            state_d  = IDLE;
            wb_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hdr_acc_c) begin
                        rw_d     = data_in[HDR_RW_BIT];
                        burst_d  = data_in[HDR_BURST_BIT];
                        addr_d   = data_in[ADDR_W-1:0];
                        wb_clear = 1'b1;
                        if (data_in[HDR_RW_BIT]) begin
                            state_d = DATA;
                        end else begin
                            state_d = HDR_RD;
                            read_d  = 1'b1;
                        end
                    end
                end
                HDR_RD, DATA: begin
                    if (state_q == HDR_RD) begin
                        wb_load = 1'b1;
                        state_d = DATA;
                    end
                    if (byte_sync) begin
                        wb_shift = 1'b1;
                        if (wb_last) begin
                            if (rw_q) begin
                                write_d = 1'b1;
                                dw_d    = wb_shifted;
                                state_d = burst_q ? DATA : HOLD;
                            end else if (burst_q) begin
                                addr_d  = addr_q + 1'b1;
                                read_d  = 1'b1;
                                state_d = HDR_RD;
                            end else begin
                                state_d = HOLD;
                            end
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // Decoder registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            burst_q <= 1'b0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            dw_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            dw_q    <= dw_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out   = wb_ms_byte;
    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign data_write = dw_q;
    assign busy       = busy_q;

endmodule
